barrel_shifter_pipe: RTL and testbench

Parametrised, pipelined successor to the 8-bit combinational rotator. Supports WIDTH-bit data, four shift/rotate modes and a valid/ready handshake with backpressure. Uses one register stage per shift-amount bit, so timing holds at large WIDTH. Sits between a producer stream and a consumer stream in datapath blocks.

---
 rtl/barrel_shifter_pipe.sv | 104 ++++++++++
 tb/tb_barrel_shifter_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined WIDTH-bit ROL/ROR/SLL/SRL, one register stage per shift-amount bit; define BARREL_SHIFTER_PIPE_FLAGS_EN for o_zero/o_cout
module barrel_shifter_pipe #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_A,
    input  logic [SHAMT_W-1:0] i_k,
    input  logic [1:0]         i_mode,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_Y
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
    ,
    output logic               o_zero,
    output logic               o_cout
`endif
);
    logic adv;
    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_st
        localparam int S  = 1 << i;
        localparam int KW = SHAMT_W - i;
        logic [WIDTH-1:0] a, r, rol, ror, dq;
        logic [KW-1:0]    k;
        logic [1:0]       m;
        logic             v, vq;
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
        logic             ci, co, cq;
`endif
        if (i == 0) begin : g_src
            assign a = i_A;
            assign k = i_k;
            assign m = i_mode;
            assign v = i_valid;
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
            assign ci = 1'b0;
`endif
        end else begin : g_src
            assign a = g_st[i-1].dq;
            assign k = g_st[i-1].g_fwd.kq;
            assign m = g_st[i-1].g_fwd.mq;
            assign v = g_st[i-1].vq;
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
            assign ci = g_st[i-1].cq;
`endif
        end
        assign rol = (a << S) | (a >> (WIDTH - S));
        assign ror = (a >> S) | (a << (WIDTH - S));
        assign r   = !k[0] ? a :
                     m == 2'd0 ? rol :
                     m == 2'd1 ? ror :
                     m == 2'd2 ? a << S : a >> S;
        // data and valid advance with the whole pipe, frozen while the output is stalled
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                dq <= '0;
                vq <= 1'b0;
            end else if (adv) begin
                dq <= r;
                vq <= v;
            end
        end
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
        assign co = m[1] ? (m[0] ? a[S-1] : a[WIDTH-S]) : (m[0] ? r[WIDTH-1] : r[0]);
        // carry-out remembers the bit from the most significant stage that actually shifted
        always_ff @(posedge i_clk) begin
            if (i_rst) cq <= 1'b0;
            else if (adv) cq <= k[0] ? co : ci;
        end
`endif
        if (i < SHAMT_W - 1) begin : g_fwd
            logic [KW-2:0] kq;
            logic [1:0]    mq;
            // only the shift-amount bits later stages still need are carried forward
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    kq <= '0;
                    mq <= '0;
                end else if (adv) begin
                    kq <= k[KW-1:1];
                    mq <= m;
                end
            end
        end
    end

    assign o_Y     = g_st[SHAMT_W-1].dq;
    assign o_valid = g_st[SHAMT_W-1].vq;

`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
    assign o_cout = g_st[SHAMT_W-1].cq;
    // zero flag registered alongside the last stage so it lines up with o_Y
    always_ff @(posedge i_clk) begin
        if (i_rst) o_zero <= 1'b0;
        else if (adv) o_zero <= g_st[SHAMT_W-1].r == '0;
    end
`endif
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed and randomized checks of barrel_shifter_pipe at WIDTH 8 and 32 against a behavioural model
module tb_barrel_shifter_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic v8 = 1'b0, r8 = 1'b1, ov8, rdy8;
    logic [7:0] a8 = '0, y8;
    logic [2:0] k8 = '0;
    logic [1:0] m8 = '0;
    logic v32 = 1'b0, r32 = 1'b1, ov32, rdy32;
    logic [31:0] a32 = '0, y32;
    logic [4:0] k32 = '0;
    logic [1:0] m32 = '0;
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
    logic z8, c8, z32, c32;
`endif

    barrel_shifter_pipe #(.WIDTH(8), .SHAMT_W(3)) u8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy8), .i_A(a8), .i_k(k8),
        .i_mode(m8), .o_valid(ov8), .i_ready(r8), .o_Y(y8)
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
        , .o_zero(z8), .o_cout(c8)
`endif
    );

    barrel_shifter_pipe #(.WIDTH(32), .SHAMT_W(5)) u32 (
        .i_clk(clk), .i_rst(rst), .i_valid(v32), .o_ready(rdy32), .i_A(a32), .i_k(k32),
        .i_mode(m32), .o_valid(ov32), .i_ready(r32), .o_Y(y32)
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
        , .o_zero(z32), .o_cout(c32)
`endif
    );

    int vectors = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {cout, zero, y} straight from the arithmetic definition of each mode
    function automatic logic [33:0] model(input logic [31:0] a, input int k, input logic [1:0] m, input int w);
        logic [63:0] x, y, msk;
        logic c;
        msk = (64'd1 << w) - 64'd1;
        x = {32'h0, a} & msk;
        case (m)
            2'd0:    y = ((x << k) | (x >> (w - k))) & msk;
            2'd1:    y = ((x >> k) | (x << (w - k))) & msk;
            2'd2:    y = (x << k) & msk;
            default: y = x >> k;
        endcase
        if (k == 0) c = 1'b0;
        else if (m == 2'd0) c = y[0];
        else if (m == 2'd1) c = y[w-1];
        else if (m == 2'd2) c = x[w-k];
        else c = x[k-1];
        return {c, y == 64'd0, y[31:0]};
    endfunction

    // scoreboard: per DUT a FIFO of expected results tagged with the advance count at acceptance
    logic [33:0] sb_x [2][16];
    int sb_t [2][16];
    int hd [2], cnt [2], advs [2], outs [2], ins [2];

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int w, sw, k;
            logic ov, ordy, iv, ir, ev;
            logic [31:0] y, a;
            logic [1:0] m;
            logic [33:0] e;
            string s;
            w = d ? 32 : 8;
            sw = d ? 5 : 3;
            s = d ? "w32" : "w8";
            ov = d ? ov32 : ov8;
            ordy = d ? rdy32 : rdy8;
            iv = d ? v32 : v8;
            ir = d ? r32 : r8;
            y = d ? y32 : 32'(y8);
            a = d ? a32 : 32'(a8);
            k = d ? int'(k32) : int'(k8);
            m = d ? m32 : m8;
            e = sb_x[d][hd[d]];
            ev = cnt[d] > 0 && advs[d] - sb_t[d][hd[d]] == sw - 1;
            if (rst) cnt[d] = 0;
            else begin
                check({s, " o_valid"}, 32'(ov), 32'(ev));
                check({s, " o_ready"}, 32'(ordy), 32'(!ev || ir));
                if (ev) begin
                    check({s, " o_Y"}, y, e[31:0]);
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
                    check({s, " o_zero"}, 32'(d ? z32 : z8), 32'(e[32]));
                    check({s, " o_cout"}, 32'(d ? c32 : c8), 32'(e[33]));
`endif
                end
                if (!ev || ir) begin
                    if (ev) begin
                        hd[d] = (hd[d] + 1) % 16;
                        cnt[d]--;
                        outs[d]++;
                    end
                    advs[d]++;
                    if (iv) begin
                        sb_x[d][(hd[d] + cnt[d]) % 16] = model(a, k, m, w);
                        sb_t[d][(hd[d] + cnt[d]) % 16] = advs[d];
                        cnt[d]++;
                        ins[d]++;
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] a, input logic [2:0] k, input logic [1:0] m);
        int n = 0;
        logic acc;
        v8 = 1'b1;
        a8 = a;
        k8 = k;
        m8 = m;
        do begin
            #1 acc = rdy8;
            tick;
            n++;
        end while (!acc && n < 50);
        v8 = 1'b0;
        check("send8 accepted", 32'(acc), 1);
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (cnt[d] != 0 && n < 100) begin
            tick;
            n++;
        end
        check("drain", cnt[d], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int o0, n, acc;
        repeat (3) tick;
        rst = 1'b0;
        check("reset o_valid w8", 32'(ov8), 0);
        check("reset o_Y w8", 32'(y8), 0);
        check("reset o_ready w8", 32'(rdy8), 1);
        check("reset o_valid w32", 32'(ov32), 0);
        check("reset o_Y w32", y32, 0);

        for (int p = 0; p < 2; p++) begin
            logic [7:0] exp_k3 [4];
            exp_k3 = '{8'hB4, 8'hD2, 8'hB0, 8'h12};
            for (int j = 0; j < 6; j++) begin
                if (j < 4) send8(8'h96, p ? 3'd3 : 3'd0, 2'(j));
                else tick;
                if (j >= 2) begin
                    check("burst o_valid", 32'(ov8), 1);
                    check(p ? "burst k3 o_Y" : "burst k0 o_Y", 32'(y8), 32'(p ? exp_k3[j-2] : 8'h96));
                end
            end
            drain(0);
        end

        o0 = outs[0];
        for (int j = 0; j < 3; j++) send8(8'($urandom), 3'($urandom), 2'($urandom));
        r8 = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick;
            check("stall o_ready", 32'(rdy8), 0);
            check("stall o_valid", 32'(ov8), 1);
        end
        r8 = 1'b1;
        for (int j = 3; j < 8; j++) send8(8'($urandom), 3'($urandom), 2'($urandom));
        drain(0);
        check("stream beats delivered", outs[0] - o0, 8);

        send8(8'hA5, 3'd1, 2'd0);
        send8(8'h5A, 3'd2, 2'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("flush o_valid", 32'(ov8), 0);
        for (int j = 0; j < 4; j++) begin
            tick;
            check("flush quiet", 32'(ov8), 0);
        end
        send8(8'h01, 3'd7, 2'd0);
        tick;
        tick;
        check("rol7 o_valid", 32'(ov8), 1);
        check("rol7 o_Y", 32'(y8), 32'h80);
        drain(0);

        n = 0;
        acc = 0;
        while (acc < 1000 && n < 20000) begin
            v32 = $urandom_range(0, 9) < 7;
            a32 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            k32 = 5'($urandom);
            m32 = 2'($urandom);
            r32 = $urandom_range(0, 9) < 7;
            #1 if (v32 && rdy32) acc++;
            tick;
            n++;
        end
        v32 = 1'b0;
        r32 = 1'b1;
        check("random beats accepted", acc, 1000);
        drain(1);
        check("random beats delivered", outs[1], ins[1]);

        v32 = 1'b1;
        a32 = 32'h8000_0000;
        k32 = 5'd1;
        m32 = 2'd2;
        #1 check("latency accept", 32'(rdy32), 1);
        tick;
        v32 = 1'b0;
        repeat (3) tick;
        check("latency early", 32'(ov32), 0);
        tick;
        check("latency 5 o_valid", 32'(ov32), 1);
        check("sll msb o_Y", y32, 0);
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
        check("sll msb o_zero", 32'(z32), 1);
        check("sll msb o_cout", 32'(c32), 1);
`endif
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
